// File: rtl/instr_encoder_if.sv
// instr_encoder_if: handshake/bus bundle for the RV32I instruction encoder.
//   master : producer side (drives the decoded instruction, out_ready; observes status)
//   slave  : encoder side (accepts the decoded instruction, drives out_code/out_addr/status)
// Input channel : in_valid/in_ready, in_instruction[5:0], in_rd/in_rs1/in_rs2[4:0], in_immi[31:0]
// Output channel: out_valid/out_ready, out_code[31:0], out_addr[ADDR_W-1:0]
// Status        : err_illegal (sticky), illegal_count[7:0] (saturating)
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_instruction;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [31:0]       in_immi;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_code;
  logic [ADDR_W-1:0] out_addr;
  logic              err_illegal;
  logic [7:0]        illegal_count;

  modport master (
    output in_valid, in_instruction, in_rd, in_rs1, in_rs2, in_immi, out_ready,
    input  in_ready, out_valid, out_code, out_addr, err_illegal, illegal_count
  );

  modport slave (
    input  in_valid, in_instruction, in_rd, in_rs1, in_rs2, in_immi, out_ready,
    output in_ready, out_valid, out_code, out_addr, err_illegal, illegal_count
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: turns a decoded instruction (6-bit ID, register fields, immediate) into a
// 32-bit RV32I machine word and tags it with a sequential byte address for imem loading.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-high reset
//   clear - synchronous clear, same effect as reset, wins over any transfer
//   bus   - instr_encoder_if.slave: input valid/ready channel, output valid/ready channel
//           carrying out_code/out_addr, plus err_illegal and illegal_count status
module instr_encoder #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  instr_encoder_if.slave bus
);

  typedef enum logic [2:0] {FmtR, FmtI, FmtSh, FmtS, FmtB, FmtJ, FmtU} fmt_e;

  logic              valid_q, valid_d;
  logic [31:0]       code_q, code_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic        in_ready, in_xfer, out_xfer;
  logic        legal;
  fmt_e        fmt;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [31:0] imm, word;
  logic [4:0]  rd, rs1, rs2;

  assign imm = bus.in_immi;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;

  // Immediate bits above the widest format (J, bit 20) are truncated.
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[31:21];

  assign in_ready = !valid_q || bus.out_ready;
  assign in_xfer  = bus.in_valid && in_ready;
  assign out_xfer = valid_q && bus.out_ready;

  // ID -> format/opcode/funct fields, same numbering as the control-unit decoder.
  always_comb begin
    legal  = 1'b1;
    fmt    = FmtR;
    opcode = 7'h33;
    f3     = 3'd0;
    f7     = 7'h00;
    case (bus.in_instruction)
      6'd0:  f3 = 3'd0;
      6'd1:  begin f3 = 3'd0; f7 = 7'h20; end
      6'd2:  f3 = 3'd4;
      6'd3:  f3 = 3'd6;
      6'd4:  f3 = 3'd7;
      6'd5:  f3 = 3'd1;
      6'd6:  f3 = 3'd5;
      6'd7:  begin f3 = 3'd5; f7 = 7'h20; end
      6'd8:  f3 = 3'd2;
      6'd9:  f3 = 3'd3;
      6'd10: begin fmt = FmtI;  opcode = 7'h13; f3 = 3'd0; end
      6'd11: begin fmt = FmtI;  opcode = 7'h13; f3 = 3'd4; end
      6'd12: begin fmt = FmtI;  opcode = 7'h13; f3 = 3'd6; end
      6'd13: begin fmt = FmtI;  opcode = 7'h13; f3 = 3'd7; end
      6'd14: begin fmt = FmtSh; opcode = 7'h13; f3 = 3'd1; end
      6'd15: begin fmt = FmtSh; opcode = 7'h13; f3 = 3'd5; end
      6'd16: begin fmt = FmtSh; opcode = 7'h13; f3 = 3'd5; f7 = 7'h20; end
      6'd17: begin fmt = FmtI;  opcode = 7'h13; f3 = 3'd2; end
      6'd18: begin fmt = FmtI;  opcode = 7'h13; f3 = 3'd3; end
      6'd19: begin fmt = FmtI;  opcode = 7'h03; f3 = 3'd0; end
      6'd20: begin fmt = FmtI;  opcode = 7'h03; f3 = 3'd1; end
      6'd21: begin fmt = FmtI;  opcode = 7'h03; f3 = 3'd2; end
      6'd22: begin fmt = FmtI;  opcode = 7'h03; f3 = 3'd4; end
      6'd23: begin fmt = FmtI;  opcode = 7'h03; f3 = 3'd5; end
      6'd24: begin fmt = FmtS;  opcode = 7'h23; f3 = 3'd0; end
      6'd25: begin fmt = FmtS;  opcode = 7'h23; f3 = 3'd1; end
      6'd26: begin fmt = FmtS;  opcode = 7'h23; f3 = 3'd2; end
      6'd27: begin fmt = FmtB;  opcode = 7'h63; f3 = 3'd0; end
      6'd28: begin fmt = FmtB;  opcode = 7'h63; f3 = 3'd1; end
      6'd29: begin fmt = FmtB;  opcode = 7'h63; f3 = 3'd4; end
      6'd32: begin fmt = FmtB;  opcode = 7'h63; f3 = 3'd5; end
      6'd33: begin fmt = FmtJ;  opcode = 7'h6F; end
      6'd34: begin fmt = FmtU;  opcode = 7'h37; end
      6'd35: begin fmt = FmtU;  opcode = 7'h17; end
      default: legal = 1'b0;
    endcase
  end

  // Field packing; register inputs a format does not use are never looked at.
  always_comb begin
    word = '0;
    case (fmt)
      FmtR:  word = {f7, rs2, rs1, f3, rd, opcode};
      FmtI:  word = {imm[11:0], rs1, f3, rd, opcode};
      FmtSh: word = {f7, imm[4:0], rs1, f3, rd, opcode};
      FmtS:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], opcode};
      FmtB:  word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opcode};
      FmtJ:  word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FmtU:  word = {imm[19:0], rd, opcode};
      default: word = '0;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    addr_d  = addr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (out_xfer) begin
      valid_d = 1'b0;
      addr_d  = addr_q + ADDR_W'(4);
    end
    if (in_xfer) begin
      if (legal) begin
        valid_d = 1'b1;
        code_d  = word;
      end else begin
        err_d = 1'b1;
        if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end
    if (clear) begin
      valid_d = 1'b0;
      code_d  = '0;
      addr_d  = BASE_ADDR;
      err_d   = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_code      = code_q;
  assign bus.out_addr      = addr_q;
  assign bus.err_illegal   = err_q;
  assign bus.illegal_count = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-encoded RV32I words, address sequencing,
// backpressure, illegal IDs, synchronous clear and asynchronous reset.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(32)) bus ();

  instr_encoder #(
    .ADDR_W   (32),
    .BASE_ADDR(32'h0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %08h required %08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] id, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    bus.in_instruction = id;
    bus.in_rd          = rd;
    bus.in_rs1         = rs1;
    bus.in_rs2         = rs2;
    bus.in_immi        = imm;
    bus.in_valid       = 1'b1;
  endtask

  // Offer one instruction for exactly one edge, then sample 1 time unit later.
  task automatic push(input logic [5:0] id, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    drive(id, rd, rs1, rs2, imm);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset              = 1'b1;
    clear              = 1'b0;
    bus.in_valid       = 1'b0;
    bus.in_instruction = '0;
    bus.in_rd          = '0;
    bus.in_rs1         = '0;
    bus.in_rs2         = '0;
    bus.in_immi        = '0;
    bus.out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_addr", bus.out_addr, 32'h0);
    check("rst_code", bus.out_code, 32'h0);
    check("rst_err", 32'(bus.err_illegal), 32'd0);
    check("rst_cnt", 32'(bus.illegal_count), 32'd0);
    reset = 1'b0;

    push(6'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    check("add_valid", 32'(bus.out_valid), 32'd1);
    check("add_code", bus.out_code, 32'h002081B3);
    check("add_addr", bus.out_addr, 32'h0);

    // Clear while the add is draining: address must return to base, not advance.
    clear = 1'b1;
    idle();
    clear = 1'b0;
    check("clr_valid", 32'(bus.out_valid), 32'd0);
    check("clr_addr", bus.out_addr, 32'h0);

    push(6'd10, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF);
    check("addi_code", bus.out_code, 32'hFFF00093);
    check("addi_addr", bus.out_addr, 32'h0);
    push(6'd16, 5'd4, 5'd4, 5'd0, 32'd3);
    check("srai_code", bus.out_code, 32'h40325213);
    check("srai_addr", bus.out_addr, 32'h4);
    push(6'd26, 5'd0, 5'd2, 5'd5, 32'd8);
    check("sw_code", bus.out_code, 32'h00512423);
    check("sw_addr", bus.out_addr, 32'h8);
    push(6'd27, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
    check("beq_code", bus.out_code, 32'hFE208EE3);
    check("beq_addr", bus.out_addr, 32'hC);
    idle();
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_addr", bus.out_addr, 32'h10);

    // Backpressure: held word must stay put, producer must see in_ready low.
    bus.out_ready = 1'b0;
    push(6'd2, 5'd5, 5'd6, 5'd7, 32'h0);
    check("xor_code", bus.out_code, 32'h007342B3);
    check("xor_addr", bus.out_addr, 32'h10);
    drive(6'd4, 5'd8, 5'd9, 5'd10, 32'h0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("bp_ready", 32'(bus.in_ready), 32'd0);
      check("bp_code", bus.out_code, 32'h007342B3);
      check("bp_addr", bus.out_addr, 32'h10);
    end
    bus.out_ready = 1'b1;
    #1;
    check("rel_ready", 32'(bus.in_ready), 32'd1);
    idle();
    bus.in_valid = 1'b0;
    check("and_code", bus.out_code, 32'h00A4F433);
    check("and_addr", bus.out_addr, 32'h14);
    check("and_valid", 32'(bus.out_valid), 32'd1);
    idle();
    check("and_drain_addr", bus.out_addr, 32'h18);

    // Illegal IDs emit nothing but are counted.
    push(6'd30, 5'd1, 5'd1, 5'd1, 32'h0);
    check("ill30_valid", 32'(bus.out_valid), 32'd0);
    check("ill30_err", 32'(bus.err_illegal), 32'd1);
    check("ill30_cnt", 32'(bus.illegal_count), 32'd1);
    push(6'd63, 5'd1, 5'd1, 5'd1, 32'h0);
    check("ill63_valid", 32'(bus.out_valid), 32'd0);
    check("ill63_cnt", 32'(bus.illegal_count), 32'd2);
    push(6'd0, 5'd3, 5'd1, 5'd2, 32'h0);
    check("add2_valid", 32'(bus.out_valid), 32'd1);
    check("add2_code", bus.out_code, 32'h002081B3);
    check("add2_addr", bus.out_addr, 32'h18);
    check("add2_cnt", 32'(bus.illegal_count), 32'd2);
    // Illegal ID while the add drains: output goes empty, address still advances.
    push(6'd31, 5'd0, 5'd0, 5'd0, 32'h0);
    check("ill31_valid", 32'(bus.out_valid), 32'd0);
    check("ill31_addr", bus.out_addr, 32'h1C);
    check("ill31_cnt", 32'(bus.illegal_count), 32'd3);
    check("ill31_err", 32'(bus.err_illegal), 32'd1);

    push(6'd34, 5'd7, 5'd0, 5'd0, 32'h00012345);
    check("lui_code", bus.out_code, 32'h123453B7);
    check("lui_addr", bus.out_addr, 32'h1C);
    push(6'd33, 5'd1, 5'd0, 5'd0, 32'd8);
    check("jal_code", bus.out_code, 32'h008000EF);
    check("jal_addr", bus.out_addr, 32'h20);
    push(6'd21, 5'd5, 5'd2, 5'd0, 32'd16);
    check("lw_code", bus.out_code, 32'h01012283);
    check("lw_addr", bus.out_addr, 32'h24);

    // Asynchronous reset mid-cycle while a word is held.
    bus.out_ready = 1'b0;
    idle();
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_addr", bus.out_addr, 32'h0);
    check("arst_cnt", 32'(bus.illegal_count), 32'd0);
    check("arst_err", 32'(bus.err_illegal), 32'd0);
    check("arst_ready", 32'(bus.in_ready), 32'd1);
    idle();
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
